// File: rtl/key_step_pkg.sv
// rtl/key_step_pkg.sv - shared constants and delta helper for the key step counter
package key_step_pkg;

    localparam int KEY_RUN = 0;
    localparam int KEY_INC = 1;
    localparam int KEY_DEC = 2;
    localparam int KEY_CLR = 3;

    localparam int COUNT_W = 8;

    // Two guard bits above the count expose both overflow (bit COUNT_W) and underflow (sign bit).
    function automatic logic [COUNT_W+1:0] step_delta(input logic inc,
                                                      input logic tick,
                                                      input logic dec);
        return {{(COUNT_W+1){1'b0}}, inc} + {{(COUNT_W+1){1'b0}}, tick}
             - {{(COUNT_W+1){1'b0}}, dec};
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - two-flop synchroniser, debouncer and press detector for one active-low key
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Only the falling (pressed) transition produces a pulse.
                stable <= sync_b;
                cnt    <= '0;
                press  <= ~sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_step_counter.sv
// rtl/key_step_counter.sv - pushbutton-driven 8-bit step/auto-run counter for the LEDG display
module key_step_counter
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_CYCLES     = 12500000
) (
    input  logic         CLOCK_50,
    input  logic         RESET,
    input  logic [3:0]   KEY,
    output logic [7:0]   LEDG,
    output logic [1:0]   LEDR
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    logic [3:0]         press;
    logic               run;
    logic               wrap_flag;
    logic [PW-1:0]      presc;
    logic [COUNT_W-1:0] count;
    logic               tick;
    logic [COUNT_W+1:0] sum;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .CLOCK_50(CLOCK_50),
            .RESET   (RESET),
            .key_raw (KEY[k]),
            .press   (press[k])
        );
    end

    assign tick = run && (presc == TICK_LAST);

    always_comb begin
        sum = {2'b00, count} + step_delta(press[KEY_INC], tick, press[KEY_DEC]);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            run       <= 1'b0;
            wrap_flag <= 1'b0;
            presc     <= '0;
            count     <= '0;
        end else begin
            if (press[KEY_RUN]) begin
                run <= ~run;
            end

            if (press[KEY_CLR] || press[KEY_RUN] || !run || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            // Clear wins over every other event and never counts as a wrap.
            if (press[KEY_CLR]) begin
                count <= '0;
            end else begin
                count <= sum[COUNT_W-1:0];
                if (|sum[COUNT_W+1:COUNT_W]) begin
                    wrap_flag <= ~wrap_flag;
                end
            end
        end
    end

    assign LEDG = count;
    assign LEDR = {wrap_flag, run};

endmodule

// File: tb/tb_key_step_counter.sv
// tb/tb_key_step_counter.sv - directed self-checking bench for key_step_counter
module tb_key_step_counter;

    logic       CLOCK_50;
    logic       RESET;
    logic [3:0] KEY;
    logic [7:0] LEDG;
    logic [1:0] LEDR;

    int tests;
    int failures;

    key_step_counter #(
        .DEBOUNCE_CYCLES(4),
        .TICK_CYCLES    (8)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .KEY     (KEY),
        .LEDG    (LEDG),
        .LEDR    (LEDR)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_keys(input logic [3:0] mask);
        KEY = KEY & ~mask;
        cyc(8);
        KEY = KEY | mask;
        cyc(8);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        KEY      = 4'hF;
        RESET    = 1'b1;
        cyc(3);
        RESET = 1'b0;
        check("reset_ledg", LEDG, 8'd0);
        check("reset_ledr", {6'd0, LEDR}, 8'd0);

        // Single increment latency and no auto-repeat
        KEY[1] = 1'b0;
        cyc(6);
        check("inc_edge6", LEDG, 8'd0);
        cyc(1);
        check("inc_edge7", LEDG, 8'd1);
        cyc(13);
        check("inc_hold", LEDG, 8'd1);
        check("inc_hold_ledr", {6'd0, LEDR}, 8'd0);
        KEY[1] = 1'b1;
        cyc(10);
        press_keys(4'b0010);
        check("inc_second", LEDG, 8'd2);

        // Clear, glitch rejection, decrement underflow
        press_keys(4'b1000);
        check("clear_to0", LEDG, 8'd0);
        KEY[2] = 1'b0;
        cyc(3);
        KEY[2] = 1'b1;
        cyc(10);
        check("glitch_rejected", LEDG, 8'd0);
        KEY[2] = 1'b0;
        cyc(10);
        check("dec_underflow", LEDG, 8'd255);
        check("dec_underflow_ledr", {6'd0, LEDR}, 8'd2);
        KEY[2] = 1'b1;
        cyc(8);
        press_keys(4'b1000);
        check("clear_keeps_wrap", {6'd0, LEDR}, 8'd2);

        // Auto-run: tick every 8 cycles, full wrap after 256 ticks
        KEY[0] = 1'b0;
        cyc(7);
        check("run_on", {6'd0, LEDR}, 8'd3);
        check("run_on_ledg", LEDG, 8'd0);
        KEY[0] = 1'b1;
        cyc(7);
        check("run_pre_tick", LEDG, 8'd0);
        cyc(1);
        check("run_tick1", LEDG, 8'd1);
        cyc(8);
        check("run_tick2", LEDG, 8'd2);
        cyc(8 * 254);
        check("run_tick256", LEDG, 8'd0);
        check("run_wrap_ledr", {6'd0, LEDR}, 8'd1);
        KEY[0] = 1'b0;
        cyc(7);
        check("run_off", {6'd0, LEDR}, 8'd0);
        cyc(20);
        check("run_frozen", LEDG, 8'd0);
        KEY[0] = 1'b1;
        cyc(8);

        // Simultaneous inc+dec cancel; clear overrides inc
        for (int i = 0; i < 5; i++) begin
            press_keys(4'b0010);
        end
        check("count_to5", LEDG, 8'd5);
        press_keys(4'b0110);
        check("inc_dec_cancel", LEDG, 8'd5);
        press_keys(4'b1010);
        check("clr_over_inc", LEDG, 8'd0);
        check("clr_over_inc_ledr", {6'd0, LEDR}, 8'd0);

        // Inc aligned with tick from 255: single wrap to 1
        press_keys(4'b0100);
        check("to255", LEDG, 8'd255);
        check("to255_ledr", {6'd0, LEDR}, 8'd2);
        KEY[0] = 1'b0;
        cyc(7);
        check("run_on2", {6'd0, LEDR}, 8'd3);
        KEY[0] = 1'b1;
        cyc(1);
        KEY[1] = 1'b0;
        cyc(6);
        check("pre_double", LEDG, 8'd255);
        cyc(1);
        check("double_step", LEDG, 8'd1);
        check("double_wrap_ledr", {6'd0, LEDR}, 8'd1);
        KEY[1] = 1'b1;

        // Reset mid-debounce while running
        cyc(64);
        check("run_to9", LEDG, 8'd9);
        KEY[1] = 1'b0;
        cyc(3);
        RESET = 1'b1;
        cyc(1);
        RESET = 1'b0;
        check("midreset_ledg", LEDG, 8'd0);
        check("midreset_ledr", {6'd0, LEDR}, 8'd0);
        cyc(6);
        check("post_reset_e6", LEDG, 8'd0);
        cyc(1);
        check("post_reset_e7", LEDG, 8'd1);
        cyc(10);
        check("post_reset_hold", LEDG, 8'd1);
        check("post_reset_ledr", {6'd0, LEDR}, 8'd0);
        KEY[1] = 1'b1;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
